// File: rtl/fpu_issue_ctrl.sv
// rtl/fpu_issue_ctrl.sv - request FIFO and issue/result sequencer in front of top_FPU
// One request is issued at a time; the result is captured after FPU_LATENCY edges.
module fpu_issue_ctrl #(
    parameter int DEPTH       = 4,
    parameter int FPU_LATENCY = 1,
    parameter int OP_W        = 2,
    parameter int DATA_W      = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OP_W-1:0]          in_op,
    input  logic [DATA_W-1:0]        in_a,
    input  logic [DATA_W-1:0]        in_b,
    output logic [OP_W-1:0]          fpu_op,
    output logic [DATA_W-1:0]        fpu_a,
    output logic [DATA_W-1:0]        fpu_b,
    input  logic [DATA_W-1:0]        fpu_out,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [DATA_W-1:0]        res_data,
    output logic [OP_W-1:0]          res_op,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam int LW    = $clog2(FPU_LATENCY) + 1;
    localparam int ENT_W = OP_W + 2 * DATA_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    logic [ENT_W-1:0]  mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    state_t            state_q, state_d;
    logic [LW-1:0]     cnt_q, cnt_d;
    logic [OP_W-1:0]   fpu_op_q, fpu_op_d;
    logic [DATA_W-1:0] fpu_a_q, fpu_a_d;
    logic [DATA_W-1:0] fpu_b_q, fpu_b_d;
    logic              res_valid_q, res_valid_d;
    logic [DATA_W-1:0] res_data_q, res_data_d;
    logic [OP_W-1:0]   res_op_q, res_op_d;

    logic              push;
    logic              pop;
    logic [OP_W-1:0]   head_op;
    logic [DATA_W-1:0] head_a;
    logic [DATA_W-1:0] head_b;

    assign in_ready = (count_q != CW'(DEPTH));
    assign push     = in_valid && in_ready;
    // Pop only on the IDLE->WAIT transition; a push this edge is not seen until the next.
    assign pop      = (state_q == S_IDLE) && (count_q != '0);

    assign {head_op, head_a, head_b} = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_op, in_a, in_b};
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            fpu_op_q    <= '0;
            fpu_a_q     <= '0;
            fpu_b_q     <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_op_q    <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fpu_op_q    <= fpu_op_d;
            fpu_a_q     <= fpu_a_d;
            fpu_b_q     <= fpu_b_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_op_q    <= res_op_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Issue registers only move on a pop, so they are frozen throughout WAIT.
    always_comb begin
        cnt_d       = cnt_q;
        fpu_op_d    = fpu_op_q;
        fpu_a_d     = fpu_a_q;
        fpu_b_d     = fpu_b_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_op_d    = res_op_q;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    fpu_op_d = head_op;
                    fpu_a_d  = head_a;
                    fpu_b_d  = head_b;
                    cnt_d    = LW'(FPU_LATENCY - 1);
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    res_data_d  = fpu_out;
                    res_op_d    = fpu_op_q;
                    res_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                end
            end
            default: begin
                res_valid_d = 1'b0;
            end
        endcase
    end

    assign fpu_op     = fpu_op_q;
    assign fpu_a      = fpu_a_q;
    assign fpu_b      = fpu_b_q;
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign res_op     = res_op_q;
    assign busy       = (state_q != S_IDLE);
    assign fifo_count = count_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb/tb_fpu_issue_ctrl.sv - self-checking bench for fpu_issue_ctrl
// dut uses FPU_LATENCY=1 with a combinational FPU model; dut4 uses FPU_LATENCY=4 with a delayed one.
module tb_fpu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        in_valid, in_valid4, res_ready;
    logic [1:0]  in_op;
    logic [31:0] in_a, in_b;

    logic        in_ready, res_valid, busy;
    logic [1:0]  fpu_op, res_op;
    logic [31:0] fpu_a, fpu_b, fpu_out, res_data;
    logic [2:0]  fifo_count;

    logic        in_ready4, res_valid4, busy4;
    logic [1:0]  fpu_op4, res_op4;
    logic [31:0] fpu_a4, fpu_b4, fpu_out4, res_data4;
    logic [2:0]  fifo_count4;

    function automatic logic [31:0] fpu_model(logic [1:0] op, logic [31:0] a, logic [31:0] b);
        if (op == 2'd0 && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        return (a ^ {b[15:0], b[31:16]}) + {30'd0, op} + 32'd1;
    endfunction

    assign fpu_out = fpu_model(fpu_op, fpu_a, fpu_b);

    logic [31:0] p4 [3] = '{default: 32'd0};
    always @(posedge clk) begin
        p4[0] <= fpu_model(fpu_op4, fpu_a4, fpu_b4);
        p4[1] <= p4[0];
        p4[2] <= p4[1];
    end
    assign fpu_out4 = p4[2];

    fpu_issue_ctrl #(.DEPTH(4), .FPU_LATENCY(1), .OP_W(2), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b),
        .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_out(fpu_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_op(res_op),
        .busy(busy), .fifo_count(fifo_count)
    );

    fpu_issue_ctrl #(.DEPTH(4), .FPU_LATENCY(4), .OP_W(2), .DATA_W(32)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .in_op(in_op), .in_a(in_a), .in_b(in_b),
        .fpu_op(fpu_op4), .fpu_a(fpu_a4), .fpu_b(fpu_b4), .fpu_out(fpu_out4),
        .res_valid(res_valid4), .res_ready(res_ready), .res_data(res_data4), .res_op(res_op4),
        .busy(busy4), .fifo_count(fifo_count4)
    );

    int total = 0;
    int bad   = 0;
    int results_seen = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(int n);
        in_op = n[1:0];
        in_a  = 32'h10000000 + n;
        in_b  = 32'h20000000 ^ (n * 32'h01010101);
    endtask

    // Scoreboard for dut: requests recorded on acceptance, results must return in order.
    logic [33:0] expq [$];
    logic [33:0] e;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic [1:0]  prev_op;

    always @(negedge clk) begin
        if (rst) begin
            expq.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && res_valid) begin
                check("hold_data", res_data, prev_data);
                check("hold_op", res_op, prev_op);
            end
            if (res_valid && res_ready) begin
                results_seen++;
                if (expq.size() == 0) begin
                    check("unexpected_result", 32'd1, 32'd0);
                end else begin
                    e = expq.pop_front();
                    check("order_data", res_data, e[31:0]);
                    check("order_op", res_op, e[33:32]);
                end
            end
            prev_stall = res_valid && !res_ready;
            prev_data  = res_data;
            prev_op    = res_op;
            if (in_valid && in_ready) expq.push_back({in_op, fpu_model(in_op, in_a, in_b)});
        end
    end

    task automatic wait_drain(string name);
        for (int c = 0; c < 200; c++) begin
            if (expq.size() == 0 && !busy && fifo_count == 3'd0) break;
            tick();
        end
        check(name, {31'd0, (expq.size() == 0 && !busy && fifo_count == 3'd0)}, 32'd1);
    endtask

    typedef struct {
        logic        iv;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        rr;
        logic        e_ir;
        logic [2:0]  e_cnt;
        logic        e_busy;
        logic        e_rv;
        logic [31:0] e_fa;
        logic [31:0] e_rd;
        logic [1:0]  e_rop;
    } vec_t;

    function automatic vec_t mk(logic iv, logic [1:0] op, logic [31:0] a, logic [31:0] b,
                                logic [2:0] ecnt, logic ebusy, logic erv, logic [31:0] efa,
                                logic [31:0] erd, logic [1:0] erop);
        vec_t v;
        v.iv = iv; v.op = op; v.a = a; v.b = b; v.rr = 1'b1; v.e_ir = 1'b1;
        v.e_cnt = ecnt; v.e_busy = ebusy; v.e_rv = erv; v.e_fa = efa;
        v.e_rd = erd; v.e_rop = erop;
        return v;
    endfunction

    vec_t vt [11];

    initial begin
        logic [31:0] a1, b1, a2, b2, la, lb, hold_a;
        int n;
        int seen0;
        logic acc;

        a1 = 32'h12345678; b1 = 32'h0BADF00D;
        a2 = 32'hCAFEBABE; b2 = 32'h55AA33CC;
        vt[0]  = mk(1, 0, 32'h3F800000, 32'h40000000, 1, 0, 0, 32'h0, 0, 0);
        vt[1]  = mk(0, 0, 0, 0, 0, 1, 0, 32'h3F800000, 0, 0);
        vt[2]  = mk(0, 0, 0, 0, 0, 1, 1, 32'h3F800000, 32'h40400000, 0);
        vt[3]  = mk(0, 0, 0, 0, 0, 0, 0, 32'h3F800000, 0, 0);
        vt[4]  = mk(1, 1, a1, b1, 1, 0, 0, 32'h3F800000, 0, 0);
        vt[5]  = mk(1, 2, a2, b2, 1, 1, 0, a1, 0, 0);
        vt[6]  = mk(0, 0, 0, 0, 1, 1, 1, a1, fpu_model(2'd1, a1, b1), 1);
        vt[7]  = mk(0, 0, 0, 0, 1, 0, 0, a1, 0, 0);
        vt[8]  = mk(0, 0, 0, 0, 0, 1, 0, a2, 0, 0);
        vt[9]  = mk(0, 0, 0, 0, 0, 1, 1, a2, fpu_model(2'd2, a2, b2), 2);
        vt[10] = mk(0, 0, 0, 0, 0, 0, 0, a2, 0, 0);

        in_valid = 0; in_valid4 = 0; res_ready = 0; in_op = 0; in_a = 0; in_b = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_count", fifo_count, 0);
        check("rst_busy", busy, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_fpu_a", fpu_a, 0);
        check("rst_res_data", res_data, 0);
        check("rst_res_op", res_op, 0);
        rst = 0;

        // Single op latency and back-to-back throughput on dut
        for (int i = 0; i < 11; i++) begin
            in_valid = vt[i].iv; in_op = vt[i].op; in_a = vt[i].a; in_b = vt[i].b;
            res_ready = vt[i].rr;
            tick();
            check($sformatf("v%0d_in_ready", i), in_ready, vt[i].e_ir);
            check($sformatf("v%0d_count", i), fifo_count, vt[i].e_cnt);
            check($sformatf("v%0d_busy", i), busy, vt[i].e_busy);
            check($sformatf("v%0d_res_valid", i), res_valid, vt[i].e_rv);
            check($sformatf("v%0d_fpu_a", i), fpu_a, vt[i].e_fa);
            if (vt[i].e_rv) begin
                check($sformatf("v%0d_res_data", i), res_data, vt[i].e_rd);
                check($sformatf("v%0d_res_op", i), res_op, vt[i].e_rop);
            end
        end
        in_valid = 0;

        // FPU_LATENCY=4: captured at T+5, issue registers frozen through WAIT
        la = 32'hA5A50001; lb = 32'h3C3C7777;
        in_valid4 = 1; in_op = 2'd3; in_a = la; in_b = lb; res_ready = 1;
        tick();
        check("lat_count_T", fifo_count4, 1);
        check("lat_busy_T", busy4, 0);
        in_valid4 = 0; in_op = 0; in_a = 0; in_b = 0;
        tick();
        check("lat_busy_T1", busy4, 1);
        check("lat_fpu_a_T1", fpu_a4, la);
        check("lat_count_T1", fifo_count4, 0);
        for (int k = 2; k <= 4; k++) begin
            tick();
            check($sformatf("lat_rv_T%0d", k), res_valid4, 0);
            check($sformatf("lat_fpu_op_T%0d", k), fpu_op4, 3);
            check($sformatf("lat_fpu_a_T%0d", k), fpu_a4, la);
            check($sformatf("lat_fpu_b_T%0d", k), fpu_b4, lb);
        end
        tick();
        check("lat_rv_T5", res_valid4, 1);
        check("lat_data_T5", res_data4, fpu_model(2'd3, la, lb));
        check("lat_op_T5", res_op4, 3);
        tick();
        check("lat_rv_T6", res_valid4, 0);
        check("lat_busy_T6", busy4, 0);

        // Fill under backpressure
        res_ready = 0;
        n = 100;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1; set_req(n + k);
            tick();
            check($sformatf("fill_count%0d", k), fifo_count, (k == 0) ? 1 : k);
        end
        check("fill_in_ready", in_ready, 0);
        set_req(n + 5);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("full_count%0d", k), fifo_count, 4);
            check($sformatf("full_in_ready%0d", k), in_ready, 0);
            check($sformatf("full_rv%0d", k), res_valid, 1);
        end
        res_ready = 1;
        tick();
        check("pulse_count", fifo_count, 4);
        res_ready = 0;
        tick();
        check("pop_count", fifo_count, 3);
        tick();
        check("sixth_count", fifo_count, 4);
        in_valid = 0; res_ready = 1;
        wait_drain("fill_drain");

        // Ordering with res_ready toggling every cycle
        seen0 = results_seen;
        n = 200;
        for (int c = 0; c < 40; c++) begin
            res_ready = c[0];
            in_valid  = (c < 3);
            set_req(n + c);
            tick();
        end
        in_valid = 0; res_ready = 1;
        wait_drain("order_drain");
        check("order_results", results_seen - seen0, 3);

        // Simultaneous push/pop with 2 entries queued, then run past pointer wrap
        res_ready = 0;
        n = 300;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1; set_req(n + k);
            tick();
        end
        in_valid = 0;
        check("sim_count_done", fifo_count, 2);
        check("sim_rv_done", res_valid, 1);
        res_ready = 1;
        tick();
        check("sim_idle_busy", busy, 0);
        check("sim_idle_count", fifo_count, 2);
        in_valid = 1; set_req(n + 3);
        tick();
        check("sim_pushpop_count", fifo_count, 2);
        check("sim_pushpop_busy", busy, 1);
        seen0 = results_seen;
        n = n + 4;
        for (int c = 0; c < 36; c++) begin
            set_req(n);
            acc = in_ready;
            tick();
            if (acc) n++;
        end
        in_valid = 0;
        wait_drain("wrap_drain");
        check("wrap_results", {31'd0, (results_seen - seen0) > 8}, 1);

        // Reset mid-WAIT on dut4 with 3 queued
        res_ready = 0;
        n = 400;
        for (int k = 0; k < 4; k++) begin
            in_valid4 = 1; set_req(n + k);
            tick();
        end
        in_valid4 = 0;
        hold_a = fpu_a4;
        check("prerst_busy", busy4, 1);
        check("prerst_count", fifo_count4, 3);
        check("prerst_fpu_a", hold_a, 32'h10000000 + 400);
        #2 rst = 1;
        #1;
        check("mid_rst_count", fifo_count4, 0);
        check("mid_rst_rv", res_valid4, 0);
        check("mid_rst_fpu_a", fpu_a4, 0);
        check("mid_rst_busy", busy4, 0);
        check("mid_rst_in_ready", in_ready4, 1);
        tick();
        rst = 0;
        res_ready = 1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check($sformatf("post_rst_rv%0d", k), res_valid4, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
